// File: rtl/tmr_vote_ctrl_if.sv
// Channel-side and output-side handshake bundle for tmr_vote_ctrl.
// The master drives the channel words and consumes the voted word. The slave is the voter.
interface tmr_vote_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [3*WIDTH-1:0] ch_data;
  logic [2:0]         ch_valid;
  logic [2:0]         ch_ready;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_mismatch;
  logic               out_fatal;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output ch_data, ch_valid, out_ready,
    input  ch_ready, out_data, out_mismatch, out_fatal, out_valid
  );

  modport slave (
    input  ch_data, ch_valid, out_ready,
    output ch_ready, out_data, out_mismatch, out_fatal, out_valid
  );
endinterface

// File: rtl/tmr_vote_ctrl.sv
// Collects one word per TMR channel, votes them LSB-first through a single shared
// 1-bit majority gate, and presents the voted word with per-channel mismatch flags.
module majority_1 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);
  assign y = (a & b) | (a & c) | (b & c);
endmodule

module tmr_vote_ctrl #(
  parameter int WIDTH     = 8,
  parameter int TIMEOUT   = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tmr_vote_ctrl_if.slave       bus,
  output logic                 timeout_err,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_VOTE    = 2'd1;
  localparam logic [1:0] S_LOAD    = 2'd2;
  localparam logic [1:0] S_OUTPUT  = 2'd3;

  logic [1:0]           state_reg;
  logic                 active_reg;
  logic [2:0]           cap_reg;
  logic [WIDTH-1:0]     word_reg [3];
  logic [TW-1:0]        timer_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [WIDTH-1:0]     result_reg;
  logic [2:0]           mm_reg;
  logic [WIDTH-1:0]     out_data_reg;
  logic [2:0]           out_mm_reg;
  logic                 out_fatal_reg;
  logic                 timeout_reg;
  logic [ERR_CNT_W-1:0] err_cnt_reg;

  logic [2:0] ch_ready_w;
  logic [2:0] take;
  logic [2:0] cap_next;
  logic [2:0] ch_bit;
  logic [2:0] ch_diff;
  logic       vote_bit;
  logic       handshake;

  // ch_ready stays low in the first cycle after reset so every output reads 0 while in reset.
  assign ch_ready_w = (state_reg == S_COLLECT && active_reg) ? ~cap_reg : 3'b000;
  assign take       = bus.ch_valid & ch_ready_w;
  assign cap_next   = cap_reg | take;
  assign handshake  = (state_reg == S_OUTPUT) && bus.out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      assign ch_bit[gi]  = word_reg[gi][idx_reg];
      assign ch_diff[gi] = ch_bit[gi] ^ vote_bit;
    end
  endgenerate

  majority_1 u_vote (
    .a (ch_bit[0]),
    .b (ch_bit[1]),
    .c (ch_bit[2]),
    .y (vote_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_COLLECT;
      active_reg    <= 1'b0;
      cap_reg       <= '0;
      timer_reg     <= '0;
      idx_reg       <= '0;
      result_reg    <= '0;
      mm_reg        <= '0;
      out_data_reg  <= '0;
      out_mm_reg    <= '0;
      out_fatal_reg <= 1'b0;
      timeout_reg   <= 1'b0;
      for (int c = 0; c < 3; c++) word_reg[c] <= '0;
    end else begin
      active_reg  <= 1'b1;
      timeout_reg <= 1'b0;
      case (state_reg)
        S_COLLECT: begin
          for (int c = 0; c < 3; c++)
            if (take[c]) word_reg[c] <= bus.ch_data[c*WIDTH +: WIDTH];
          // Completing the set wins over a timeout expiring on the same edge.
          if (cap_next == 3'b111) begin
            cap_reg   <= cap_next;
            timer_reg <= '0;
            idx_reg   <= '0;
            mm_reg    <= '0;
            state_reg <= S_VOTE;
          end else if (cap_reg != 3'b000) begin
            if (timer_reg == TW'(TIMEOUT - 1)) begin
              timeout_reg <= 1'b1;
              cap_reg     <= '0;
              timer_reg   <= '0;
            end else begin
              cap_reg   <= cap_next;
              timer_reg <= timer_reg + 1'b1;
            end
          end else begin
            cap_reg <= cap_next;
          end
        end
        S_VOTE: begin
          result_reg[idx_reg] <= vote_bit;
          mm_reg              <= mm_reg | ch_diff;
          if (idx_reg == IDX_W'(WIDTH - 1)) begin
            idx_reg   <= '0;
            state_reg <= S_LOAD;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        S_LOAD: begin
          out_data_reg  <= result_reg;
          out_mm_reg    <= mm_reg;
          out_fatal_reg <= (mm_reg[0] & mm_reg[1]) | (mm_reg[0] & mm_reg[2]) | (mm_reg[1] & mm_reg[2]);
          state_reg     <= S_OUTPUT;
        end
        default: begin
          if (bus.out_ready) begin
            cap_reg       <= '0;
            timer_reg     <= '0;
            mm_reg        <= '0;
            out_data_reg  <= '0;
            out_mm_reg    <= '0;
            out_fatal_reg <= 1'b0;
            state_reg     <= S_COLLECT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_reg <= '0;
    end else if (err_clr) begin
      err_cnt_reg <= '0;
    end else if (handshake && out_mm_reg != 3'b000 && err_cnt_reg != {ERR_CNT_W{1'b1}}) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign bus.ch_ready     = ch_ready_w;
  assign bus.out_data     = out_data_reg;
  assign bus.out_mismatch = out_mm_reg;
  assign bus.out_fatal    = out_fatal_reg;
  assign bus.out_valid    = (state_reg == S_OUTPUT);
  assign timeout_err      = timeout_reg;
  assign err_cnt          = err_cnt_reg;
endmodule

// File: tb/tb_tmr_vote_ctrl.sv
// Directed bench for tmr_vote_ctrl: a vector table of voted words plus hand-written
// sequences for timeout, capture/timeout priority, backpressure, reset and counter saturation.
module tb_tmr_vote_ctrl;
  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       timeout_err;
  logic       err_clr;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;
  int err_model = 0;
  int txn = 0;

  tmr_vote_ctrl_if #(.WIDTH(WIDTH)) bus ();

  tmr_vote_ctrl #(.WIDTH(WIDTH), .TIMEOUT(16), .ERR_CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .timeout_err (timeout_err),
    .err_clr     (err_clr),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] exp_data;
    logic [2:0] exp_mm;
    logic       exp_fatal;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic capture_all(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    bus.ch_data  = {d2, d1, d0};
    bus.ch_valid = 3'b111;
    step();
    bus.ch_valid = 3'b000;
  endtask

  // Called right after the third capture edge; waits for the word, checks it, optionally holds
  // backpressure, then completes the handshake.
  task automatic finish_word(input logic [7:0] exp_data, input logic [2:0] exp_mm,
                             input logic exp_fatal, input logic clr, input int hold);
    int cyc;
    int bad;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 30) begin
      step();
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(WIDTH + 1));
    chk("out_data", 32'(bus.out_data), 32'(exp_data));
    chk("out_mismatch", 32'(bus.out_mismatch), 32'(exp_mm));
    chk("out_fatal", 32'(bus.out_fatal), 32'(exp_fatal));
    chk("ch_ready_busy", 32'(bus.ch_ready), 32'(3'b000));
    bad = 0;
    if (hold > 0) begin
      bus.ch_valid = 3'b111;
      for (int k = 0; k < hold; k++) begin
        step();
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_data || bus.ch_ready !== 3'b000
            || timeout_err !== 1'b0) bad++;
      end
      bus.ch_valid = 3'b000;
      chk("hold_stable", 32'(bad), 32'(0));
    end
    bus.out_ready = 1'b1;
    err_clr       = clr;
    step();
    bus.out_ready = 1'b0;
    err_clr       = 1'b0;
    if (clr) err_model = 0;
    else if (exp_mm != 3'b000 && err_model != 255) err_model++;
    chk("out_valid_after_hs", 32'(bus.out_valid), 32'(0));
    chk("ch_ready_after_hs", 32'(bus.ch_ready), 32'(3'b111));
    chk("err_cnt", 32'(err_cnt), 32'(err_model));
    txn++;
    $display("txn %0d: data=%02h mm=%03b fatal=%0b lat=%0d err_cnt=%0d", txn, bus.out_data,
             exp_mm, exp_fatal, cyc, err_cnt);
  endtask

  initial begin
    int first;
    int pulses;
    int seen_valid;

    vecs[0] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 3'b000, 1'b0};
    vecs[1] = '{8'hA5, 8'hA5, 8'h25, 8'hA5, 3'b100, 1'b0};
    vecs[2] = '{8'hFF, 8'h0F, 8'hF0, 8'hFF, 3'b110, 1'b1};
    vecs[3] = '{8'h00, 8'hFF, 8'h00, 8'h00, 3'b010, 1'b0};
    vecs[4] = '{8'h5A, 8'h5A, 8'hA5, 8'h5A, 3'b100, 1'b0};
    vecs[5] = '{8'h3C, 8'hC3, 8'hC3, 8'hC3, 3'b001, 1'b0};
    vecs[6] = '{8'h12, 8'h34, 8'h56, 8'h16, 3'b111, 1'b1};

    rst_n        = 1'b0;
    bus.ch_data  = '0;
    bus.ch_valid = 3'b000;
    bus.out_ready = 1'b0;
    err_clr      = 1'b0;
    step();
    step();
    chk("rst_ch_ready", 32'(bus.ch_ready), 32'(0));
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_out_data", 32'(bus.out_data), 32'(0));
    chk("rst_mismatch", 32'(bus.out_mismatch), 32'(0));
    chk("rst_fatal", 32'(bus.out_fatal), 32'(0));
    chk("rst_timeout", 32'(timeout_err), 32'(0));
    chk("rst_err_cnt", 32'(err_cnt), 32'(0));
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", 32'(bus.ch_ready), 32'(3'b111));

    for (int i = 0; i < 7; i++) begin
      capture_all(vecs[i].d0, vecs[i].d1, vecs[i].d2);
      finish_word(vecs[i].exp_data, vecs[i].exp_mm, vecs[i].exp_fatal, 1'b0, 0);
    end

    // Timeout with only ch0 and ch1 delivered.
    bus.ch_data  = {8'h00, 8'h11, 8'h22};
    bus.ch_valid = 3'b011;
    step();
    bus.ch_valid = 3'b000;
    first = 0;
    pulses = 0;
    seen_valid = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) chk("ready_partial", 32'(bus.ch_ready), 32'(3'b100));
      if (timeout_err === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (bus.out_valid === 1'b1) seen_valid++;
    end
    chk("timeout_at", 32'(first), 32'(16));
    chk("timeout_pulses", 32'(pulses), 32'(1));
    chk("timeout_no_valid", 32'(seen_valid), 32'(0));
    chk("timeout_ready", 32'(bus.ch_ready), 32'(3'b111));
    $display("txn timeout: pulse at cycle %0d", first);

    // Third capture lands on the edge where the timer would expire.
    bus.ch_data  = {8'h00, 8'h00, 8'h0F};
    bus.ch_valid = 3'b001;
    step();
    bus.ch_valid = 3'b000;
    repeat (15) step();
    chk("prio_no_early_timeout", 32'(timeout_err), 32'(0));
    bus.ch_data  = {8'hFF, 8'h0F, 8'h00};
    bus.ch_valid = 3'b110;
    step();
    bus.ch_valid = 3'b000;
    chk("prio_timeout", 32'(timeout_err), 32'(0));
    finish_word(8'h0F, 3'b100, 1'b0, 1'b0, 0);

    // Backpressure for 20 cycles.
    capture_all(8'h12, 8'h34, 8'h56);
    finish_word(8'h16, 3'b111, 1'b1, 1'b0, 20);

    // Reset in the middle of VOTE abandons the word.
    capture_all(8'hA5, 8'hA5, 8'h25);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    chk("midrst_ch_ready", 32'(bus.ch_ready), 32'(0));
    chk("midrst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("midrst_out_data", 32'(bus.out_data), 32'(0));
    chk("midrst_err_cnt", 32'(err_cnt), 32'(0));
    err_model = 0;
    rst_n = 1'b1;
    seen_valid = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (bus.out_valid === 1'b1) seen_valid++;
    end
    chk("midrst_abandoned", 32'(seen_valid), 32'(0));
    $display("txn reset-in-vote: out_valid seen %0d times", seen_valid);

    // Drive the counter to saturation, past it, then clear on an incrementing handshake.
    for (int i = 0; i < 256; i++) begin
      capture_all(8'hA5, 8'hA5, 8'h25);
      finish_word(8'hA5, 3'b100, 1'b0, 1'b0, 0);
    end
    chk("err_saturated", 32'(err_cnt), 32'(255));
    capture_all(8'hA5, 8'hA5, 8'h25);
    finish_word(8'hA5, 3'b100, 1'b0, 1'b1, 0);
    chk("err_cleared", 32'(err_cnt), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
